// File: rtl/pll_divider_bank_if.sv
// Configuration-write bus for pll_divider_bank: one-cycle write strobe with
// channel select and new divide/high/phase fields, plus the registered
// reject pulse returned by the divider bank.
interface pll_divider_bank_if #(
   parameter int NUM_OUT = 6,
   parameter int DIV_W   = 8
);
   localparam int SEL_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

   logic             CFG_WE;
   logic [SEL_W-1:0] CFG_SEL;
   logic [DIV_W-1:0] CFG_DIVIDE;
   logic [DIV_W-1:0] CFG_HIGH;
   logic [DIV_W-1:0] CFG_PHASE;
   logic             CFG_ERR;

   // Host side: issues writes, observes rejects
   modport master (
      output CFG_WE, CFG_SEL, CFG_DIVIDE, CFG_HIGH, CFG_PHASE,
      input  CFG_ERR
   );

   // Divider-bank side: accepts writes, flags rejects
   modport slave (
      input  CFG_WE, CFG_SEL, CFG_DIVIDE, CFG_HIGH, CFG_PHASE,
      output CFG_ERR
   );
endinterface

// File: rtl/pll_divider_bank.sv
// Cycle-based bank of clock-divider channels behind a lock sequencer.
// Every channel counts CLKIN1 cycles modulo its divide value; the outputs are
// gated by LOCKED so nothing toggles while locking or powered down. Any
// accepted configuration write re-locks the bank and re-aligns every channel
// to its phase preload, so all channels start together again.
module pll_divider_bank #(
   parameter int NUM_OUT     = 6,
   parameter int DIV_W       = 8,
   parameter int LOCK_CYCLES = 64,
   parameter logic [NUM_OUT*DIV_W-1:0] INIT_DIVIDE = {NUM_OUT{8'd2}},
   parameter logic [NUM_OUT*DIV_W-1:0] INIT_HIGH   = {NUM_OUT{8'd1}},
   parameter logic [NUM_OUT*DIV_W-1:0] INIT_PHASE  = {NUM_OUT{8'd0}}
) (
   input  logic               CLKIN1,
   input  logic               RST,
   input  logic               PWRDWN,
   pll_divider_bank_if.slave  cfg,
   output logic [NUM_OUT-1:0] CLKOUT,
   output logic [NUM_OUT-1:0] CLKOUT_EN,
   output logic               LOCKED
);
   localparam int SEL_W  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
   localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

   typedef enum logic [1:0] {LOCKING, RUN, PWRDN} state_t;

   state_t            state;
   logic [LOCK_W-1:0] lock_cnt;
   logic              err_reg;
   logic              wr_bad;
   logic              wr_ok;
   logic              run_step;

   // Validate the write fields against the rules a divider can honour
   always_comb begin
      wr_bad = 1'b0;
      if (32'(cfg.CFG_SEL) >= NUM_OUT)
         wr_bad = 1'b1;
      if (cfg.CFG_DIVIDE == '0)
         wr_bad = 1'b1;
      if (cfg.CFG_PHASE >= cfg.CFG_DIVIDE)
         wr_bad = 1'b1;
      if ((cfg.CFG_DIVIDE >= DIV_W'(2)) &&
          ((cfg.CFG_HIGH == '0) || (cfg.CFG_HIGH >= cfg.CFG_DIVIDE)))
         wr_bad = 1'b1;
      wr_ok = cfg.CFG_WE & ~wr_bad;
   end

   // Counters only advance in a RUN cycle that is not being interrupted by
   // power-down or by a re-lock; every other cycle reloads the phase preload.
   assign run_step = (state == RUN) & ~PWRDWN & ~wr_ok;

   // Lock sequencer: power-down wins, then re-lock on write or wake-up
   always_ff @(posedge CLKIN1 or posedge RST) begin
      if (RST) begin
         state    <= LOCKING;
         lock_cnt <= '0;
         err_reg  <= 1'b0;
      end else begin
         err_reg <= cfg.CFG_WE & wr_bad;
         if (PWRDWN) begin
            state    <= PWRDN;
            lock_cnt <= '0;
         end else if (wr_ok || (state == PWRDN)) begin
            state    <= LOCKING;
            lock_cnt <= '0;
         end else if (state == LOCKING) begin
            if (lock_cnt == LOCK_LAST)
               state <= RUN;
            else
               lock_cnt <= lock_cnt + 1'b1;
         end
      end
   end

   assign LOCKED      = (state == RUN);
   assign cfg.CFG_ERR = err_reg;

   generate
      for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_chan
         localparam logic [DIV_W-1:0] INIT_D  = INIT_DIVIDE[gi*DIV_W +: DIV_W];
         localparam logic [DIV_W-1:0] INIT_H  = INIT_HIGH[gi*DIV_W +: DIV_W];
         localparam logic [DIV_W-1:0] INIT_PH = INIT_PHASE[gi*DIV_W +: DIV_W];
         localparam logic [DIV_W-1:0] INIT_PRE =
            (INIT_PH == '0) ? '0 : DIV_W'(INIT_D - INIT_PH);

         logic [DIV_W-1:0] div_reg;
         logic [DIV_W-1:0] high_reg;
         logic [DIV_W-1:0] ph_reg;
         logic [DIV_W-1:0] cnt_reg;
         logic [DIV_W-1:0] preload;
         logic             sel_hit;

         // (div - ph) mod div, with ph < div guaranteed by write validation
         assign preload = (ph_reg == '0) ? '0 : (div_reg - ph_reg);
         assign sel_hit = wr_ok & (cfg.CFG_SEL == SEL_W'(gi));

         // Channel configuration, retained across power-down
         always_ff @(posedge CLKIN1 or posedge RST) begin
            if (RST) begin
               div_reg  <= INIT_D;
               high_reg <= INIT_H;
               ph_reg   <= INIT_PH;
            end else if (sel_hit) begin
               div_reg  <= cfg.CFG_DIVIDE;
               high_reg <= cfg.CFG_HIGH;
               ph_reg   <= cfg.CFG_PHASE;
            end
         end

         // Modulo-div cycle counter, parked at the phase preload when not running
         always_ff @(posedge CLKIN1 or posedge RST) begin
            if (RST)
               cnt_reg <= INIT_PRE;
            else if (run_step)
               cnt_reg <= (cnt_reg == div_reg - DIV_W'(1)) ? '0 : cnt_reg + DIV_W'(1);
            else
               cnt_reg <= preload;
         end

         // Divide-by-one passes LOCKED straight through regardless of high time
         assign CLKOUT[gi]    = LOCKED & ((div_reg == DIV_W'(1)) | (cnt_reg < high_reg));
         assign CLKOUT_EN[gi] = LOCKED & (cnt_reg == '0);
      end
   endgenerate
endmodule

// File: tb/tb_pll_divider_bank.sv
// Self-checking bench for pll_divider_bank. Each cycle the expected outputs
// are derived from elapsed time since the expected lock point and pushed to a
// scoreboard queue; they are popped and compared after the clock edge.
module tb_pll_divider_bank;
   localparam int NUM_OUT = 6;
   localparam int DIV_W   = 8;
   localparam int LOCK    = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic               pwrdwn;
   logic [NUM_OUT-1:0] clkout;
   logic [NUM_OUT-1:0] clkout_en;
   logic               locked;

   pll_divider_bank_if #(.NUM_OUT(NUM_OUT), .DIV_W(DIV_W)) cfg ();

   pll_divider_bank #(
      .NUM_OUT(NUM_OUT), .DIV_W(DIV_W), .LOCK_CYCLES(LOCK)
   ) dut (
      .CLKIN1(clk), .RST(rst), .PWRDWN(pwrdwn), .cfg(cfg),
      .CLKOUT(clkout), .CLKOUT_EN(clkout_en), .LOCKED(locked)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic               locked;
      logic [NUM_OUT-1:0] clkout;
      logic [NUM_OUT-1:0] en;
      logic               err;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   tdiv[NUM_OUT];
   int   thigh[NUM_OUT];
   int   tph[NUM_OUT];
   bit   pd;
   int   cyc;
   int   lock_edge;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic bit is_bad(input int sel, input int d, input int h, input int p);
      return (sel >= NUM_OUT) || (d == 0) || (p >= d) || ((d >= 2) && ((h == 0) || (h >= d)));
   endfunction

   // Expected outputs k cycles into a lock: channel position is (div-ph+k) mod div
   function automatic exp_t model_out();
      exp_t e;
      int   k;
      int   c;
      e = '0;
      e.locked = !pd && (cyc >= lock_edge);
      if (e.locked) begin
         k = cyc - lock_edge;
         for (int i = 0; i < NUM_OUT; i++) begin
            if (tdiv[i] == 1) begin
               e.clkout[i] = 1'b1;
               e.en[i]     = 1'b1;
            end else begin
               c = (tdiv[i] - tph[i] + k) % tdiv[i];
               e.clkout[i] = (c < thigh[i]);
               e.en[i]     = (c == 0);
            end
         end
      end
      return e;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NUM_OUT; i++) begin
         tdiv[i]  = 2;
         thigh[i] = 1;
         tph[i]   = 0;
      end
      pd        = 1'b0;
      cyc       = 0;
      lock_edge = LOCK;
   endtask

   // One CLKIN1 cycle: drive inputs, push expectation, compare after the edge
   task automatic step(input bit pd_in, input bit we, input int sel, input int d,
                       input int h, input int p);
      exp_t e;
      bit   bad;
      @(negedge clk);
      pwrdwn         = pd_in;
      cfg.CFG_WE     = we;
      cfg.CFG_SEL    = sel[2:0];
      cfg.CFG_DIVIDE = d[7:0];
      cfg.CFG_HIGH   = h[7:0];
      cfg.CFG_PHASE  = p[7:0];
      cyc++;
      bad = we && is_bad(sel, d, h, p);
      if (we && !bad) begin
         tdiv[sel]  = d;
         thigh[sel] = h;
         tph[sel]   = p;
      end
      if (pd_in)
         pd = 1'b1;
      else if ((we && !bad) || pd) begin
         pd        = 1'b0;
         lock_edge = cyc + LOCK;
      end
      e     = model_out();
      e.err = bad;
      sb_q.push_back(e);
      if (we)
         $display("cycle %0d: write sel=%0d div=%0d high=%0d ph=%0d pwrdwn=%0b -> %s",
                  cyc, sel, d, h, p, pd_in, bad ? "rejected" : "accepted");
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check_val("locked", locked, e.locked);
      check_val("clkout", clkout, e.clkout);
      check_val("clkout_en", clkout_en, e.en);
      check_val("cfg_err", cfg.CFG_ERR, e.err);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(1'b0, 1'b0, 0, 0, 0, 0);
   endtask

   initial begin
      rst            = 1'b1;
      pwrdwn         = 1'b0;
      cfg.CFG_WE     = 1'b0;
      cfg.CFG_SEL    = '0;
      cfg.CFG_DIVIDE = '0;
      cfg.CFG_HIGH   = '0;
      cfg.CFG_PHASE  = '0;
      #1;
      check_val("rst_locked", locked, 0);
      check_val("rst_clkout", clkout, 0);
      check_val("rst_clkout_en", clkout_en, 0);
      check_val("rst_cfg_err", cfg.CFG_ERR, 0);
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      model_reset();

      // Default lock and 1,0,1,0 patterns
      idle(12);

      // Reconfigure ch1 while running
      step(1'b0, 1'b1, 1, 5, 2, 3);
      idle(14);

      // Rejected writes leave everything running
      step(1'b0, 1'b1, 1, 5, 5, 0);
      idle(1);
      step(1'b0, 1'b1, 2, 2, 1, 2);
      idle(1);
      step(1'b0, 1'b1, 7, 2, 1, 0);
      idle(1);
      step(1'b0, 1'b1, 3, 0, 0, 0);
      idle(2);

      // Power-down for 10 cycles with an accepted write inside it
      for (int i = 0; i < 4; i++)
         step(1'b1, 1'b0, 0, 0, 0, 0);
      step(1'b1, 1'b1, 2, 3, 1, 1);
      for (int i = 0; i < 5; i++)
         step(1'b1, 1'b0, 0, 0, 0, 0);
      idle(12);

      // Divide-by-one on ch0
      step(1'b0, 1'b1, 0, 1, 0, 0);
      idle(10);

      // Asynchronous reset between edges
      check_val("pre_rst_locked", locked, 1);
      #2 rst = 1'b1;
      #1;
      check_val("async_locked", locked, 0);
      check_val("async_clkout", clkout, 0);
      check_val("async_clkout_en", clkout_en, 0);
      @(posedge clk);
      #2 rst = 1'b0;
      model_reset();
      idle(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pll_divider_bank.md
# pll_divider_bank

Cycle-based, parametrised successor to the team's PLL primitive models: a bank of NUM_OUT clock-divider channels driven from one input clock, with per-channel divide, high-time and phase, a lock sequencer, power-down, and runtime reconfiguration. Used as the Verilator-friendly clock generator behind PLL wrappers. Every output is derived from registers clocked by CLKIN1, so no real-valued timing or delays are involved.

## Interface
- NUM_OUT, 6, number of output channels (1..8)
- DIV_W, 8, width of divide/high/phase fields
- LOCK_CYCLES, 64, CLKIN1 cycles from start of locking to LOCKED (>=1)
- INIT_DIVIDE, {NUM_OUT{8'd2}}, packed per-channel reset divide (channel i at bits [i*DIV_W +: DIV_W])
- INIT_HIGH, {NUM_OUT{8'd1}}, packed per-channel reset high time in cycles
- INIT_PHASE, {NUM_OUT{8'd0}}, packed per-channel reset phase offset in cycles

Ports:
- CLKIN1  in  1  the single clock; all state is on its rising edge
- RST  in  1  asynchronous, active-high reset
- PWRDWN  in  1  power-down request, sampled synchronously
- CFG_WE  in  1  one-cycle config write strobe
- CFG_SEL  in  clog2(NUM_OUT) (min 1)  channel to write
- CFG_DIVIDE  in  DIV_W  new divide
- CFG_HIGH  in  DIV_W  new high time
- CFG_PHASE  in  DIV_W  new phase
- CFG_ERR  out  1  one-cycle pulse: last write was rejected
- CLKOUT  out  NUM_OUT  divided clocks
- CLKOUT_EN  out  NUM_OUT  one-cycle strobe marking each channel's rising edge
- LOCKED  out  1  outputs valid and running

## Operation
- Per-channel config registers div_i, high_i, ph_i; RST loads INIT_* values.
- State machine: LOCKING, RUN, PWRDN. RST forces LOCKING with lock counter 0.
- LOCKING: lock counter increments each cycle; at LOCK_CYCLES-1 go to RUN. Channel counters held at preload (div_i - ph_i) mod div_i.
- RUN: cnt_i <= (cnt_i == div_i-1) ? 0 : cnt_i+1.
- LOCKED = (state == RUN).
- CLKOUT[i] = LOCKED & (cnt_i < high_i).
- CLKOUT_EN[i] = LOCKED & (cnt_i == 0).
- div_i == 1: CLKOUT[i] and CLKOUT_EN[i] equal LOCKED (high_i ignored).
- Write validation. Reject if any of:
  - CFG_SEL >= NUM_OUT
  - CFG_DIVIDE == 0
  - CFG_PHASE >= CFG_DIVIDE
  - CFG_DIVIDE >= 2 and (CFG_HIGH == 0 or CFG_HIGH >= CFG_DIVIDE)
- Rejected write: config unchanged, state unchanged, CFG_ERR pulses.
- Accepted write:
  - Updates that channel's config.
  - From RUN or LOCKING: enter LOCKING with lock counter 0 and all channels re-preloaded, so channels are phase-aligned again.
  - From PWRDN: state stays PWRDN.
- PWRDWN = 1 in any state: enter PWRDN; outputs low; config retained.
- PWRDWN falling while in PWRDN: enter LOCKING with lock counter 0.
- Simultaneous PWRDWN = 1 and accepted CFG_WE: config updated, state goes to PWRDN.

## Timing
- Reset values: CLKOUT = 0, CLKOUT_EN = 0, LOCKED = 0, CFG_ERR = 0. All counters are preloaded from the INIT_* values.
- LOCKED rises on the LOCK_CYCLES-th CLKIN1 rising edge after RST deasserts, provided PWRDWN stays low.
- In the first LOCKED cycle, channel i is at cnt = (div_i - ph_i) mod div_i, so its first CLKOUT_EN is ph_i cycles after LOCKED rises.
- Accepted write on edge k:
  - LOCKED low from edge k.
  - LOCKED high again from edge k + LOCK_CYCLES.
  - A further accepted write during LOCKING restarts the count.
- CFG_ERR is registered: high for exactly the cycle after the rejected write's edge.
- PWRDWN sampled high on edge k: LOCKED and all CLKOUT low from edge k.
- RST asserted mid-run: all outputs go to reset values immediately, without waiting for a clock edge. Config returns to INIT_*.
- Period of channel i = div_i CLKIN1 cycles; high for high_i of them.
- Counter arithmetic is DIV_W-bit unsigned and never wraps past div_i-1.

## Test plan
- Reset release, defaults with LOCK_CYCLES = 4 -> LOCKED rises 4 edges after RST falls; all CLKOUT toggle 1,0,1,0 starting in the LOCKED cycle; CLKOUT_EN high every 2nd cycle.
- Write ch1 divide = 5, high = 2, phase = 3 while running -> LOCKED drops next cycle, relocks 4 cycles later. First ch1 CLKOUT_EN occurs 3 cycles after LOCKED; ch1 pattern is 1,1,0,0,0 thereafter.
- Invalid writes: high = 5 with divide = 5; phase = 2 with divide = 2; CFG_SEL = 7 with NUM_OUT = 6 -> CFG_ERR pulses once per write; LOCKED stays 1; outputs undisturbed.
- PWRDWN asserted for 10 cycles mid-run, plus an accepted write during power-down -> outputs 0 throughout. After PWRDWN falls, LOCKED returns after 4 cycles with the new config.
- RST asserted asynchronously between edges while locked -> LOCKED and CLKOUT drop without a clock edge; config reverts to INIT_*.
- Divide = 1 on ch0 -> CLKOUT[0] and CLKOUT_EN[0] constant 1 while LOCKED.
